arithmetic_unit: RTL and testbench
==================================

Name: arithmetic_unit

Overview:
- Unsigned integer arithmetic unit of the 19-bit CPU datapath.
- Executes ADD, SUB, MUL, DIV, INC and DEC on two WORD_SIZE operands, selected by the opcode on the control bus.
- Result and status flags are registered: one clock of latency, consumed by writeback and the flag register.

Parameters:
- WORD_SIZE, 19, operand/result width (from package constants)
- OPCODE_SIZE, 5, opcode width (from package constants)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  operation request; operands/opcode sampled when high
- opcode  input  OPCODE_SIZE  operation select, driven from ctrl_bus_if.opcode
- operand_1  input  WORD_SIZE  first operand (dividend, minuend, INC/DEC source)
- operand_2  input  WORD_SIZE  second operand; ignored for INC/DEC
- out  output  WORD_SIZE  registered result
- out_valid  output  1  high for one cycle when out/flags are updated
- zero  output  1  out == 0
- carry  output  1  carry-out (ADD/INC) or borrow (SUB/DEC)
- overflow  output  1  MUL product exceeds WORD_SIZE bits
- div_by_zero  output  1  DIV with operand_2 == 0
- illegal_op  output  1  en with an opcode not listed below

Behaviour:
- Reset: on a rising clk with rst=1, all outputs go to 0. rst has priority over en.
- Latency: operands are sampled at rising edge N with en=1. out, the flags and out_valid=1 appear after edge N; they are stable by edge N+1.
- Back-to-back: one operation is accepted per cycle; there is no stall or back-pressure.
- Idle: when en=0, out_valid=0 the next cycle. out and the flags hold their last values.
- All arithmetic is unsigned and modulo 2^WORD_SIZE.
- ADD: out = (op1+op2)[18:0]; carry = bit 19 of the sum.
- SUB: out = (op1-op2) mod 2^19; carry = 1 if op2 > op1 (borrow).
- MUL: out = low 19 bits of the 38-bit product; overflow = 1 if any upper bit is set. The product is computed in a single cycle.
- DIV: out = floor(op1/op2).
  - If op2 == 0: out = all ones (19'h7FFFF), div_by_zero = 1.
  - Remainder is discarded.
- INC: out = op1+1; carry = 1 when op1 = 19'h7FFFF (out wraps to 0).
- DEC: out = op1-1; carry = 1 when op1 = 0 (out wraps to 19'h7FFFF).
- Flags not defined for the executed opcode are cleared to 0 in that result cycle.
- zero is computed from the new out value for every legal opcode.
- Illegal opcode with en=1:
  - out = 0, illegal_op = 1, all other flags 0, out_valid = 1.
  - zero stays 0 so an illegal operation is not mistaken for a zero result.
- Reset asserted mid-stream: the pending result is discarded; outputs read 0 after the reset edge.

Decomposition:
- Package constants: WORD_SIZE=19, OPCODE_SIZE=5.
- Package opcodes: ADD=5'h00, SUB=5'h01, MUL=5'h02, DIV=5'h03, INC=5'h04, DEC=5'h05; all other codes are reserved for other units.
- Package typedef: opcode_t.
- One natural sub-module: au_divider, a combinational unsigned divider with quotient and div_by_zero outputs, isolated for later replacement by a multi-cycle version.
- The rest is a combinational opcode case feeding one output register stage.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and garbage operands -> out=0, out_valid=0, all flags 0.
- Basic ops, one per cycle, checked one cycle after issue:
  - ADD 10,5 -> 15
  - SUB 10,5 -> 5
  - MUL 3,4 -> 12
  - DIV 20,4 -> 5
  - INC 10,x -> 11
  - DEC 10,x -> 9
  - out_valid=1 each cycle, zero=0, other flags 0.
- Wrap and carry:
  - ADD 19'h7FFFF,1 -> out=0, carry=1, zero=1.
  - SUB 5,10 -> out=19'h7FFFB, carry=1.
  - DEC 0 -> out=19'h7FFFF, carry=1.
  - INC 19'h7FFFF -> out=0, carry=1, zero=1.
- MUL overflow: 19'h400,19'h400 -> out=0, overflow=1, zero=1. Then 1000,300 -> out=300000, overflow=0.
- Divide edges:
  - DIV 7,0 -> out=19'h7FFFF, div_by_zero=1.
  - DIV 7,9 -> out=0, zero=1.
  - DIV 19'h7FFFF,1 -> out=19'h7FFFF.
- Control:
  - Opcode 5'h1F with en=1 -> illegal_op=1, out=0, zero=0.
  - en=0 for 3 cycles -> out_valid=0, out holds previous value.
  - rst pulsed right after issuing ADD 1,2 -> out reads 0, not 3.

Source files
------------

// File: rtl/arithmetic_unit_pkg.sv
// Shared constants and opcode encoding for the datapath arithmetic unit.
package arithmetic_unit_pkg;
  localparam int WORD_SIZE   = 19;
  localparam int OPCODE_SIZE = 5;

  typedef enum logic [OPCODE_SIZE-1:0] {
    OP_ADD = 5'h00,
    OP_SUB = 5'h01,
    OP_MUL = 5'h02,
    OP_DIV = 5'h03,
    OP_INC = 5'h04,
    OP_DEC = 5'h05
  } opcode_t;
endpackage

// File: rtl/arithmetic_unit_divider.sv
// Combinational unsigned divider; kept separate so a multi-cycle divider can drop in later.
module au_divider #(
  parameter int W = 19
) (
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         div_by_zero_o
);
  always_comb begin
    div_by_zero_o = (divisor_i == '0);
    // Divide-by-zero saturates to all ones rather than leaving X from the operator.
    quotient_o    = div_by_zero_o ? '1 : dividend_i / divisor_i;
  end
endmodule

// File: rtl/arithmetic_unit.sv
// Unsigned ADD/SUB/MUL/DIV/INC/DEC with one registered result stage and status flags.
module arithmetic_unit
  import arithmetic_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic [WORD_SIZE-1:0]   operand_1,
  input  logic [WORD_SIZE-1:0]   operand_2,
  output logic [WORD_SIZE-1:0]   out,
  output logic                   out_valid,
  output logic                   zero,
  output logic                   carry,
  output logic                   overflow,
  output logic                   div_by_zero,
  output logic                   illegal_op
);
  localparam int W = WORD_SIZE;

  logic [W-1:0]   out_q, out_d;
  logic           valid_q, zero_q, zero_d, carry_q, carry_d;
  logic           ovf_q, ovf_d, dbz_q, dbz_d, ill_q, ill_d;

  logic [W:0]     sum, diff, incr, decr;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic           quot_dbz;

  assign sum  = {1'b0, operand_1} + {1'b0, operand_2};
  assign diff = {1'b0, operand_1} - {1'b0, operand_2};
  assign incr = {1'b0, operand_1} + (W+1)'(1);
  assign decr = {1'b0, operand_1} - (W+1)'(1);
  assign prod = (2*W)'(operand_1) * (2*W)'(operand_2);

  au_divider #(.W(W)) u_div (
    .dividend_i    (operand_1),
    .divisor_i     (operand_2),
    .quotient_o    (quot),
    .div_by_zero_o (quot_dbz)
  );

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dbz_d   = 1'b0;
    ill_d   = 1'b0;
    case (opcode)
      OP_ADD: begin out_d = sum[W-1:0];  carry_d = sum[W];  end
      OP_SUB: begin out_d = diff[W-1:0]; carry_d = diff[W]; end
      OP_MUL: begin out_d = prod[W-1:0]; ovf_d = |prod[2*W-1:W]; end
      OP_DIV: begin out_d = quot;        dbz_d = quot_dbz;  end
      OP_INC: begin out_d = incr[W-1:0]; carry_d = incr[W]; end
      OP_DEC: begin out_d = decr[W-1:0]; carry_d = decr[W]; end
      default: ill_d = 1'b1;
    endcase
    // An illegal op reports out=0 but must not look like a genuine zero result.
    zero_d = ~ill_d && (out_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        out_q   <= out_d;
        zero_q  <= zero_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        dbz_q   <= dbz_d;
        ill_q   <= ill_d;
      end
    end
  end

  assign out         = out_q;
  assign out_valid   = valid_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;
endmodule

// File: tb/tb_arithmetic_unit.sv
// Directed vector bench for arithmetic_unit: table-driven ops plus reset/idle sequences.
module tb_arithmetic_unit;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [4:0]  opcode;
  logic [18:0] operand_1, operand_2;
  logic [18:0] out;
  logic        out_valid, zero, carry, overflow, div_by_zero, illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  arithmetic_unit dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .operand_1(operand_1), .operand_2(operand_2),
    .out(out), .out_valid(out_valid), .zero(zero), .carry(carry),
    .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [18:0] a, b;
    logic [18:0] e_out;
    logic        e_zero, e_carry, e_ovf, e_dbz, e_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [4:0] op, logic [18:0] a, logic [18:0] b,
                              logic [18:0] e_out, logic e_zero, logic e_carry,
                              logic e_ovf, logic e_dbz, logic e_ill);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.e_out = e_out;
    v.e_zero = e_zero; v.e_carry = e_carry; v.e_ovf = e_ovf; v.e_dbz = e_dbz; v.e_ill = e_ill;
    return v;
  endfunction

  // Packed view {out, valid, zero, carry, ovf, dbz, ill} compared in one shot.
  task automatic check(string name, logic [18:0] e_out, logic e_valid, logic e_zero,
                       logic e_carry, logic e_ovf, logic e_dbz, logic e_ill);
    logic [24:0] got, exp;
    got = {out, out_valid, zero, carry, overflow, div_by_zero, illegal_op};
    exp = {e_out, e_valid, e_zero, e_carry, e_ovf, e_dbz, e_ill};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got out=%h v=%b z=%b c=%b o=%b d=%b i=%b, want out=%h v=%b z=%b c=%b o=%b d=%b i=%b",
               name, out, out_valid, zero, carry, overflow, div_by_zero, illegal_op,
               e_out, e_valid, e_zero, e_carry, e_ovf, e_dbz, e_ill);
    end
  endtask

  task automatic drive(logic r, logic e, logic [4:0] op, logic [18:0] a, logic [18:0] b);
    @(negedge clk);
    rst = r; en = e; opcode = op; operand_1 = a; operand_2 = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; opcode = 5'h02; operand_1 = 19'h5A5A5; operand_2 = 19'h3C3C3;

    //               name         op     a         b         out       z c o d i
    vecs.push_back(mk("add",      5'h00, 19'd10,   19'd5,    19'd15,   0,0,0,0,0));
    vecs.push_back(mk("sub",      5'h01, 19'd10,   19'd5,    19'd5,    0,0,0,0,0));
    vecs.push_back(mk("mul",      5'h02, 19'd3,    19'd4,    19'd12,   0,0,0,0,0));
    vecs.push_back(mk("div",      5'h03, 19'd20,   19'd4,    19'd5,    0,0,0,0,0));
    vecs.push_back(mk("inc",      5'h04, 19'd10,   19'h12345,19'd11,   0,0,0,0,0));
    vecs.push_back(mk("dec",      5'h05, 19'd10,   19'h7FFFF,19'd9,    0,0,0,0,0));
    vecs.push_back(mk("add_wrap", 5'h00, 19'h7FFFF,19'd1,    19'd0,    1,1,0,0,0));
    vecs.push_back(mk("sub_brw",  5'h01, 19'd5,    19'd10,   19'h7FFFB,0,1,0,0,0));
    vecs.push_back(mk("dec_wrap", 5'h05, 19'd0,    19'd0,    19'h7FFFF,0,1,0,0,0));
    vecs.push_back(mk("inc_wrap", 5'h04, 19'h7FFFF,19'd0,    19'd0,    1,1,0,0,0));
    vecs.push_back(mk("mul_ovf",  5'h02, 19'h400,  19'h400,  19'd0,    1,0,1,0,0));
    vecs.push_back(mk("mul_big",  5'h02, 19'd1000, 19'd300,  19'd300000,0,0,0,0,0));
    vecs.push_back(mk("div_zero", 5'h03, 19'd7,    19'd0,    19'h7FFFF,0,0,0,1,0));
    vecs.push_back(mk("div_small",5'h03, 19'd7,    19'd9,    19'd0,    1,0,0,0,0));
    vecs.push_back(mk("illegal",  5'h1F, 19'd7,    19'd9,    19'd0,    0,0,0,0,1));
    vecs.push_back(mk("div_max",  5'h03, 19'h7FFFF,19'd1,    19'h7FFFF,0,0,0,0,0));

    // Reset held two cycles with en=1 and garbage operands.
    drive(1'b1, 1'b1, 5'h02, 19'h5A5A5, 19'h3C3C3);
    check("reset_1", 19'd0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 5'h00, 19'h7FFFF, 19'h7FFFF);
    check("reset_2", 19'd0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].e_out, 1'b1, vecs[i].e_zero, vecs[i].e_carry,
            vecs[i].e_ovf, vecs[i].e_dbz, vecs[i].e_ill);
    end

    // Idle: outputs and flags hold, only out_valid drops.
    drive(1'b0, 1'b1, 5'h00, 19'h7FFFE, 19'd3);
    check("add_carry_hold", 19'd1, 1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 5'h03, 19'd0, 19'd0);
      check($sformatf("idle_%0d", k), 19'd1, 0, 0, 1, 0, 0, 0);
    end

    // Reset right after issuing ADD 1,2 discards the result.
    drive(1'b0, 1'b1, 5'h00, 19'd1, 19'd2);
    check("add_pre_rst", 19'd3, 1, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 5'h00, 19'd1, 19'd2);
    check("mid_rst", 19'd0, 0, 0, 0, 0, 0, 0);

    // rst wins over en on the same edge.
    drive(1'b1, 1'b1, 5'h00, 19'd4, 19'd4);
    check("rst_prio", 19'd0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 5'h00, 19'd4, 19'd4);
    check("post_rst_add", 19'd8, 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
